// File: rtl/mult54_operand_packer.sv
// ============================================================================
// Module   : mult54_operand_packer
// Purpose  : Packs serial 5-bit element pairs into 54-bit A/B operand words
//            for the 12-slot packed multiplier. Optional macro: PACK_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult54_operand_packer #(
    parameter int SLOTS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_a,
    input  logic [4:0]  in_b,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [53:0] out_a,
    output logic [53:0] out_b,
    output logic [3:0]  out_count,
    output logic [3:0]  out_lanes,
    output logic        out_sat
);

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        PARKED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  slot_ptr_q, slot_ptr_d;
    logic [53:0] asm_a_q, asm_a_d;
    logic [53:0] asm_b_q, asm_b_d;
    logic        asm_sat_q, asm_sat_d;
    logic [3:0]  park_count_q, park_count_d;
    logic        park_sat_q, park_sat_d;
    logic        out_valid_q, out_valid_d;
    logic [53:0] out_a_q, out_a_d;
    logic [53:0] out_b_q, out_b_d;
    logic [3:0]  out_count_q, out_count_d;
    logic [3:0]  out_lanes_q, out_lanes_d;
    logic        out_sat_q, out_sat_d;

    logic        w_accept;
    logic        w_close;
    logic        w_out_free;
    logic [3:0]  w_count;
    logic [3:0]  w_odd_a;
    logic [3:0]  w_odd_b;
    logic        w_odd_sat;
    logic        w_field_sat;
    logic        w_merge_sat;
    logic [53:0] w_merge_a;
    logic [53:0] w_merge_b;

    // Lane g covers slots 3g..3g+2, so it is occupied once count exceeds 3g.
    function automatic logic [3:0] lanes_of(input logic [3:0] cnt);
        return {cnt > 4'd9, cnt > 4'd6, cnt > 4'd3, cnt != 4'd0};
    endfunction

    assign in_ready   = (state_q == FILL);
    assign w_accept   = in_valid && in_ready;
    assign w_close    = w_accept && (in_last || (slot_ptr_q == 4'(SLOTS - 1)));
    assign w_out_free = !out_valid_q || out_ready;
    assign w_count    = slot_ptr_q + 4'd1;

`ifdef PACK_SAT_EN
    // A 5-bit value fits in 4 signed bits only when bits 4 and 3 agree.
    always_comb begin
        w_odd_a   = (in_a[4] ^ in_a[3]) ? (in_a[4] ? 4'h8 : 4'h7) : in_a[3:0];
        w_odd_b   = (in_b[4] ^ in_b[3]) ? (in_b[4] ? 4'h8 : 4'h7) : in_b[3:0];
        w_odd_sat = (in_a[4] ^ in_a[3]) || (in_b[4] ^ in_b[3]);
    end
`else
    always_comb begin
        w_odd_a   = in_a[3:0];
        w_odd_b   = in_b[3:0];
        w_odd_sat = 1'b0;
    end
`endif

    always_comb begin
        w_merge_a   = asm_a_q;
        w_merge_b   = asm_b_q;
        w_field_sat = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (slot_ptr_q == 4'(k)) begin
                if ((k % 2) == 0) begin
                    w_merge_a[9*(k/2) +: 5] = in_a;
                    w_merge_b[9*(k/2) +: 5] = in_b;
                end else begin
                    w_merge_a[9*(k/2)+5 +: 4] = w_odd_a;
                    w_merge_b[9*(k/2)+5 +: 4] = w_odd_b;
                    w_field_sat               = w_odd_sat;
                end
            end
        end
        w_merge_sat = asm_sat_q | w_field_sat;
    end

    always_comb begin
        state_d      = state_q;
        slot_ptr_d   = slot_ptr_q;
        asm_a_d      = asm_a_q;
        asm_b_d      = asm_b_q;
        asm_sat_d    = asm_sat_q;
        park_count_d = park_count_q;
        park_sat_d   = park_sat_q;
        out_valid_d  = out_valid_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        out_count_d  = out_count_q;
        out_lanes_d  = out_lanes_q;
        out_sat_d    = out_sat_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (w_accept) begin
                    if (w_close) begin
                        slot_ptr_d = 4'd0;
                        asm_a_d    = '0;
                        asm_b_d    = '0;
                        asm_sat_d  = 1'b0;
                        if (w_out_free) begin
                            out_valid_d = 1'b1;
                            out_a_d     = w_merge_a;
                            out_b_d     = w_merge_b;
                            out_count_d = w_count;
                            out_lanes_d = lanes_of(w_count);
                            out_sat_d   = w_merge_sat;
                        end else begin
                            // Output still held: the finished packet waits in the assembly registers.
                            asm_a_d      = w_merge_a;
                            asm_b_d      = w_merge_b;
                            park_count_d = w_count;
                            park_sat_d   = w_merge_sat;
                            state_d      = PARKED;
                        end
                    end else begin
                        asm_a_d    = w_merge_a;
                        asm_b_d    = w_merge_b;
                        asm_sat_d  = w_merge_sat;
                        slot_ptr_d = slot_ptr_q + 4'd1;
                    end
                end
            end
            PARKED: begin
                if (w_out_free) begin
                    out_valid_d = 1'b1;
                    out_a_d     = asm_a_q;
                    out_b_d     = asm_b_q;
                    out_count_d = park_count_q;
                    out_lanes_d = lanes_of(park_count_q);
                    out_sat_d   = park_sat_q;
                    asm_a_d     = '0;
                    asm_b_d     = '0;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            slot_ptr_q   <= 4'd0;
            asm_a_q      <= '0;
            asm_b_q      <= '0;
            asm_sat_q    <= 1'b0;
            park_count_q <= 4'd0;
            park_sat_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_count_q  <= 4'd0;
            out_lanes_q  <= 4'd0;
            out_sat_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_ptr_q   <= slot_ptr_d;
            asm_a_q      <= asm_a_d;
            asm_b_q      <= asm_b_d;
            asm_sat_q    <= asm_sat_d;
            park_count_q <= park_count_d;
            park_sat_q   <= park_sat_d;
            out_valid_q  <= out_valid_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_count_q  <= out_count_d;
            out_lanes_q  <= out_lanes_d;
            out_sat_q    <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_count = out_count_q;
    assign out_lanes = out_lanes_q;
    assign out_sat   = out_sat_q;

endmodule

`default_nettype wire
